// File: rtl/seq_match_monitor.sv
// Counts single-cycle match pulses from the 1010 detector over back-to-back
// programmable windows, reporting per-window totals, a sticky alarm and a lifetime count.
module seq_match_monitor #(
  parameter int CNT_W = 8,
  parameter int WIN_W = 16,
  parameter int TOT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             z,
  input  logic [WIN_W-1:0] win_len,
  input  logic [CNT_W-1:0] thresh,
  input  logic             clr,
  output logic [CNT_W-1:0] win_cnt,
  output logic [CNT_W-1:0] last_cnt,
  output logic             win_done,
  output logic             alarm,
  output logic [TOT_W-1:0] total
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [WIN_W-1:0] timer_q;
  logic [CNT_W-1:0] thr_q;

  logic             win_end;
  logic             start;
  logic             run_cnt;
  logic             alarm_set;
  logic             tot_inc;
  logic [CNT_W-1:0] cnt_next;
  logic [WIN_W-1:0] len_eff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // The window timer counts down to 0; the cycle it reads 0 is the window's last.
  always_comb begin
    state_d  = state_q;
    win_end  = 1'b0;
    start    = 1'b0;
    run_cnt  = 1'b0;
    len_eff  = win_len;
    cnt_next = win_cnt;
    if (win_len == '0) len_eff = WIN_W'(1);
    if (z && (win_cnt != '1)) cnt_next = win_cnt + CNT_W'(1);
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = RUN;
          start   = 1'b1;
        end
      end
      RUN: begin
        win_end = (timer_q == '0);
        if (!en) state_d = IDLE;
        else     start   = win_end;
        run_cnt = en && !win_end;
      end
      default: state_d = IDLE;
    endcase
    alarm_set = win_end && (thr_q != '0) && (cnt_next >= thr_q);
    tot_inc   = (state_q == RUN) && z && (total != '1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q  <= '0;
      thr_q    <= '0;
      win_cnt  <= '0;
      last_cnt <= '0;
      win_done <= 1'b0;
      alarm    <= 1'b0;
      total    <= '0;
    end else begin
      if (start) begin
        thr_q   <= thresh;
        timer_q <= len_eff - WIN_W'(1);
      end else if (state_q == RUN && en) begin
        timer_q <= timer_q - WIN_W'(1);
      end else begin
        thr_q   <= '0;
        timer_q <= '0;
      end

      // A final-cycle match belongs to the ending window, hence cnt_next here.
      win_cnt  <= run_cnt ? cnt_next : '0;
      win_done <= win_end;
      if (win_end) last_cnt <= cnt_next;

      if (alarm_set) alarm <= 1'b1;
      else if (clr)  alarm <= 1'b0;

      if (clr)          total <= '0;
      else if (tot_inc) total <= total + TOT_W'(1);
    end
  end

endmodule

// File: tb/tb_seq_match_monitor.sv
// Directed bench for seq_match_monitor: completed-window totals are queued when a
// window is driven and checked against last_cnt whenever win_done pulses.
module tb_seq_match_monitor;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        z;
  logic [15:0] win_len;
  logic [7:0]  thresh;
  logic        clr;
  logic [7:0]  win_cnt;
  logic [7:0]  last_cnt;
  logic        win_done;
  logic        alarm;
  logic [15:0] total;

  logic [7:0]  exp_q[$];
  int          n_checks;
  int          n_fail;

  seq_match_monitor dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .z        (z),
    .win_len  (win_len),
    .thresh   (thresh),
    .clr      (clr),
    .win_cnt  (win_cnt),
    .last_cnt (last_cnt),
    .win_done (win_done),
    .alarm    (alarm),
    .total    (total)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive z for one cycle, then look at the registered outputs just after the edge.
  task automatic tick(input logic zv);
    z = zv;
    @(posedge clk);
    #1;
    if (win_done) begin
      if (exp_q.size() != 0) chk("sb_last_cnt", 32'(last_cnt), 32'(exp_q.pop_front()));
      else                   chk("spurious_win_done", 32'(win_done), 32'd0);
    end
  endtask

  task automatic start_run();
    en = 1'b1;
    tick(1'b0);
  endtask

  task automatic stop_run();
    en = 1'b0;
    tick(1'b0);
    tick(1'b0);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick(1'b0);
    clr = 1'b0;
  endtask

  initial begin
    logic zr;
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    en       = 1'b0;
    z        = 1'b0;
    win_len  = 16'd0;
    thresh   = 8'd0;
    clr      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_win_cnt", 32'(win_cnt), 32'd0);
    chk("rst_last_cnt", 32'(last_cnt), 32'd0);
    chk("rst_win_done", 32'(win_done), 32'd0);
    chk("rst_alarm", 32'(alarm), 32'd0);
    chk("rst_total", 32'(total), 32'd0);
    rst_n = 1'b1;
    tick(1'b0);

    // Window count: 8-cycle window, matches on cycles 2 and 5
    win_len = 16'd8;
    thresh  = 8'd2;
    start_run();
    exp_q.push_back(8'd2);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        win_len = 16'd3;
        thresh  = 8'd9;
      end
      tick(i == 2 || i == 5);
      if (i == 5) chk("t1_win_cnt_mid", 32'(win_cnt), 32'd2);
      if (i == 6) chk("t1_no_early_done", 32'(win_done), 32'd0);
    end
    chk("t1_win_done", 32'(win_done), 32'd1);
    chk("t1_alarm", 32'(alarm), 32'd1);
    chk("t1_total", 32'(total), 32'd2);
    chk("t1_win_cnt_restart", 32'(win_cnt), 32'd0);
    stop_run();
    pulse_clr();
    chk("clr_alarm", 32'(alarm), 32'd0);
    chk("clr_total", 32'(total), 32'd0);

    // Boundary match on the final cycle of a 4-cycle window
    win_len = 16'd4;
    thresh  = 8'd1;
    start_run();
    exp_q.push_back(8'd1);
    for (int i = 0; i < 4; i++) tick(i == 3);
    chk("t2_win_done", 32'(win_done), 32'd1);
    chk("t2_win_cnt_next", 32'(win_cnt), 32'd0);
    chk("t2_alarm", 32'(alarm), 32'd1);
    stop_run();
    pulse_clr();

    // Abort: en drops at window cycle 6 of a 10-cycle window
    win_len = 16'd10;
    thresh  = 8'd2;
    start_run();
    for (int i = 0; i < 6; i++) begin
      tick(i == 0 || i == 2 || i == 4);
      if (i == 4) chk("t3_win_cnt_mid", 32'(win_cnt), 32'd3);
    end
    en = 1'b0;
    tick(1'b0);
    chk("t3_no_win_done", 32'(win_done), 32'd0);
    chk("t3_win_cnt", 32'(win_cnt), 32'd0);
    chk("t3_last_cnt", 32'(last_cnt), 32'd1);
    chk("t3_total", 32'(total), 32'd3);
    chk("t3_alarm", 32'(alarm), 32'd0);
    tick(1'b0);
    chk("t3_idle_done", 32'(win_done), 32'd0);
    pulse_clr();

    // Saturation with clr on the alarm-set cycle
    win_len = 16'd300;
    thresh  = 8'd200;
    start_run();
    exp_q.push_back(8'd255);
    for (int i = 0; i < 300; i++) begin
      if (i == 299) clr = 1'b1;
      tick(1'b1);
      if (i == 298) begin
        chk("t4_win_cnt_sat", 32'(win_cnt), 32'd255);
        chk("t4_alarm_before", 32'(alarm), 32'd0);
        chk("t4_total_before", 32'(total), 32'd299);
      end
    end
    clr = 1'b0;
    chk("t4_win_done", 32'(win_done), 32'd1);
    chk("t4_alarm_wins", 32'(alarm), 32'd1);
    chk("t4_total_cleared", 32'(total), 32'd0);
    stop_run();
    pulse_clr();

    // Zero threshold never raises the alarm
    win_len = 16'd3;
    thresh  = 8'd0;
    start_run();
    exp_q.push_back(8'd3);
    for (int i = 0; i < 3; i++) tick(1'b1);
    chk("t5_win_done", 32'(win_done), 32'd1);
    chk("t5_alarm", 32'(alarm), 32'd0);
    stop_run();

    // win_len 0 behaves as 1: every RUN cycle closes a window
    pulse_clr();
    win_len = 16'd0;
    start_run();
    for (int i = 0; i < 8; i++) begin
      zr = 1'($urandom_range(0, 1));
      exp_q.push_back({7'd0, zr});
      tick(zr);
      chk("t6_win_done", 32'(win_done), 32'd1);
    end
    en = 1'b0;
    exp_q.push_back(8'd1);
    tick(1'b1);
    chk("t6_end_on_last", 32'(win_done), 32'd1);
    tick(1'b0);
    chk("t6_idle_done", 32'(win_done), 32'd0);
    chk("t6_alarm", 32'(alarm), 32'd0);

    // Async reset mid-window with alarm and total = 5
    pulse_clr();
    win_len = 16'd5;
    thresh  = 8'd1;
    start_run();
    exp_q.push_back(8'd5);
    for (int i = 0; i < 5; i++) tick(1'b1);
    chk("t7_alarm_pre", 32'(alarm), 32'd1);
    chk("t7_total_pre", 32'(total), 32'd5);
    tick(1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_rst_win_cnt", 32'(win_cnt), 32'd0);
    chk("t7_rst_last_cnt", 32'(last_cnt), 32'd0);
    chk("t7_rst_win_done", 32'(win_done), 32'd0);
    chk("t7_rst_alarm", 32'(alarm), 32'd0);
    chk("t7_rst_total", 32'(total), 32'd0);
    win_len = 16'd2;
    thresh  = 8'd0;
    rst_n   = 1'b1;
    tick(1'b0);
    exp_q.push_back(8'd1);
    tick(1'b1);
    chk("t7_first_cnt", 32'(win_cnt), 32'd1);
    tick(1'b0);
    chk("t7_first_done", 32'(win_done), 32'd1);
    stop_run();

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_match_monitor.md
# seq_match_monitor

Downstream consumer of the 1010 sequence detector's Moore match output `z`. It counts single-cycle match pulses over back-to-back programmable observation windows. At each window end it reports the window total and raises a sticky alarm when the total reaches a threshold. It also keeps a saturating lifetime match count for status readout.

## Interface
- `CNT_W`, 8, width of the per-window and last-window match counters.
- `WIN_W`, 16, width of the window-length input and internal window timer.
- `TOT_W`, 16, width of the lifetime match counter.

Ports:
- `clk`  input  1  single clock; all state updates on rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `en`  input  1  monitor enable; level-sensitive.
- `z`  input  1  match pulse from the detector; one count per high cycle.
- `win_len`  input  WIN_W  window length in cycles; latched at each window start.
- `thresh`  input  CNT_W  alarm threshold; latched at each window start.
- `clr`  input  1  synchronous clear of `alarm` and `total`.
- `win_cnt`  output  CNT_W  matches so far in the current window.
- `last_cnt`  output  CNT_W  match total of the most recently completed window.
- `win_done`  output  1  single-cycle pulse marking a window completion.
- `alarm`  output  1  sticky flag: a completed window had `last_cnt >= thresh`.
- `total`  output  TOT_W  lifetime matches counted while in RUN.

## Operation
- The block uses a two-state FSM.
  - IDLE: entered on reset or whenever `en` is 0. `z` is ignored. Timer, `win_cnt` and latched parameters are held at 0.
  - RUN: entered from IDLE the cycle after `en` is sampled 1. Leaving RUN for IDLE happens the cycle after `en` is sampled 0.
- Window start (the IDLE->RUN transition and every window restart):
  - latch `thresh` into `thr_q`;
  - latch `win_len` into `len_q`; `win_len == 0` is treated as 1;
  - load the timer with `len_q - 1`.
- Each cycle in RUN:
  - if `z` = 1, `win_cnt` increments, saturating at 2^CNT_W-1;
  - `total` increments, saturating at 2^TOT_W-1;
  - the timer decrements.
- Window end is the RUN cycle with timer = 0. On the next edge:
  - `last_cnt <= win_cnt + z`, saturating, so a match on the final cycle belongs to the ending window;
  - `win_cnt <= 0`;
  - `win_done` pulses for one cycle;
  - a new window starts immediately with no gap cycle.
- Alarm set condition: window end with `thr_q != 0` and `(win_cnt + z) >= thr_q`. The compare uses the saturated value.
- `clr` = 1 clears `alarm` and `total` on the next edge. If an alarm set and `clr` occur in the same cycle, the set wins and `alarm` stays 1. If a `total` increment and `clr` occur in the same cycle, `total` becomes 0 and that match is dropped.
- If `en` drops mid-window, the partial window is discarded:
  - `win_cnt` goes to 0;
  - no `win_done` pulse;
  - `last_cnt`, `alarm` and `total` hold.
- If `en` drops on the window-end cycle, the window completes normally (`win_done`, `last_cnt`, alarm update) and the FSM goes to IDLE.
- Changing `win_len` or `thresh` mid-window has no effect until the next window start.

## Timing
- Reset values: FSM = IDLE, `win_cnt` = 0, `last_cnt` = 0, `win_done` = 0, `alarm` = 0, `total` = 0, timer = 0.
- Reset is asynchronous. Asserting it mid-window clears everything immediately, with no `win_done`.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Latency:
  - `z` high in cycle t is reflected in `win_cnt` and `total` at t+1;
  - `last_cnt`, `win_done` and `alarm` update at t+1 after the window-end cycle t.
- Window period is exactly `len_q` cycles in RUN. The first window begins the cycle after `en` is sampled high.
- The detector's `z` is at most one cycle per match and is consumed every cycle. There is no handshake and no backpressure.

## Test plan
- Window count: `win_len`=8, `thresh`=2, `en`=1; `z` pulses in window cycles 2 and 5 -> `win_done` pulses once after 8 RUN cycles, `last_cnt`=2, `alarm`=1, `total`=2.
- Boundary match: `win_len`=4, `z` high only on window cycle 3 (the last cycle) -> `last_cnt`=1; `win_cnt`=0 in the first cycle of the next window.
- Abort: `win_len`=10, 3 matches, `en` dropped at window cycle 6 -> no `win_done`, `win_cnt`=0, `last_cnt` unchanged, `total`=3.
- Saturation, clear priority and zero threshold:
  - `CNT_W`=8, `z` held high for 300 cycles with `win_len`=300 -> `last_cnt`=255;
  - `clr` asserted on the same cycle as that window's alarm set -> `alarm` stays 1 and `total` reads 0;
  - `thresh`=0 over any window -> `alarm` stays 0.
- `win_len`=0 -> treated as 1: `win_done` pulses every cycle and `last_cnt` mirrors the previous cycle's `z`.
- Async reset asserted mid-window with `alarm`=1 and `total`=5 -> all outputs are 0 immediately. After release, the first window starts the cycle after `en` is sampled 1.
